// File: rtl/dffram_burst_reader_pkg.sv
// Shared constants and FSM encoding for the DFFRAM burst reader.
// RAM geometry matches the 512x32 DFFRAM instance it reads from.
package dffram_burst_reader_pkg;

    localparam int A_WIDTH   = 9;
    localparam int D_WIDTH   = 32;
    localparam int LEN_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/dffram_rd_skid.sv
// Two-entry FIFO between the RAM read port and the output stream.
// Entry 0 is the head, so the outputs come straight from registers.
module dffram_rd_skid
    import dffram_burst_reader_pkg::*;
#(
    parameter int W = D_WIDTH + 1
)
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem0_r;
    logic [W-1:0] mem1_r;
    logic [1:0]   occ_r;
    logic         do_pop_s;
    logic         do_push_s;

    assign do_pop_s  = pop && (occ_r != 2'd0);
    assign do_push_s = push && ((occ_r != 2'd2) || do_pop_s);

    // Storage and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem0_r <= {W{1'b0}};
            mem1_r <= {W{1'b0}};
            occ_r  <= 2'd0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        mem0_r <= din;
                    end else begin
                        mem1_r <= din;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    mem0_r <= mem1_r;
                    occ_r  <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        mem0_r <= din;
                    end else begin
                        mem0_r <= mem1_r;
                        mem1_r <= din;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign head  = mem0_r;
    assign occ   = occ_r;
    assign full  = (occ_r == 2'd2);
    assign empty = (occ_r == 2'd0);

endmodule

// File: rtl/dffram_burst_reader.sv
// Drains a burst of words from DFFRAM port 0 onto a valid/ready stream,
// throttling reads so the two-entry skid FIFO can never overflow.
module dffram_burst_reader
    import dffram_burst_reader_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [A_WIDTH-1:0]   base_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_en,
    output logic [3:0]           ram_we,
    output logic [A_WIDTH-1:0]   ram_addr,
    input  logic [D_WIDTH-1:0]   ram_do,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [D_WIDTH-1:0]   m_data,
    output logic                 m_last
);

    state_e                 state_r;
    state_e                 state_s;
    logic [LEN_WIDTH-1:0]   len_r;
    logic [LEN_WIDTH-1:0]   issue_cnt_r;
    logic [A_WIDTH-1:0]     addr_r;
    logic                   inflight_r;
    logic                   inflight_last_r;
    logic                   ram_en_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   credit_s;
    logic                   final_issue_s;
    logic [D_WIDTH:0]       skid_head_s;
    logic [1:0]             skid_occ_s;
    logic                   skid_full_s;
    logic                   skid_empty_s;

    assign pop_s         = m_valid && m_ready;
    assign final_issue_s = (issue_cnt_r == (len_r - {{(LEN_WIDTH-1){1'b0}}, 1'b1}));
    // A read may issue only if its word has a FIFO slot when it lands next cycle.
    assign credit_s      = (({1'b0, skid_occ_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));
    assign push_s        = inflight_r && (!skid_full_s || pop_s);

    // Next-state and read-issue decode.
    always_comb begin
        state_s  = state_r;
        ram_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (len == {LEN_WIDTH{1'b0}}) ? ST_DONE : ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (credit_s) begin
                    ram_en_s = 1'b1;
                    state_s  = final_issue_s ? ST_DRAIN : ST_ISSUE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (pop_s && m_last) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Burst parameters, issue/address counters and the in-flight read tag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_r           <= {LEN_WIDTH{1'b0}};
            issue_cnt_r     <= {LEN_WIDTH{1'b0}};
            addr_r          <= {A_WIDTH{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && start) begin
                len_r       <= len;
                issue_cnt_r <= {LEN_WIDTH{1'b0}};
                addr_r      <= base_addr;
            end else if (ram_en_s) begin
                issue_cnt_r <= issue_cnt_r + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                addr_r      <= addr_r + {{(A_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                addr_r <= addr_r;
            end
            inflight_r      <= ram_en_s;
            inflight_last_r <= ram_en_s && final_issue_s;
        end
    end

    dffram_rd_skid #(
        .W (D_WIDTH + 1)
    ) u_skid (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push_s),
        .din   ({inflight_last_r, ram_do}),
        .pop   (pop_s),
        .head  (skid_head_s),
        .occ   (skid_occ_s),
        .full  (skid_full_s),
        .empty (skid_empty_s)
    );

    assign busy     = (state_r != ST_IDLE);
    assign done     = (state_r == ST_DONE);
    assign ram_en   = ram_en_s;
    assign ram_we   = 4'b0000;
    assign ram_addr = addr_r;
    assign m_valid  = !skid_empty_s;
    assign m_data   = skid_head_s[D_WIDTH-1:0];
    assign m_last   = skid_head_s[D_WIDTH];

endmodule

// File: tb/tb_dffram_burst_reader.sv
// Bench for dffram_burst_reader: behavioural DFFRAM model, queue scoreboard,
// table of bursts plus hand-written reset and start-while-busy sequences.
module tb_dffram_burst_reader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  len;
    logic        busy;
    logic        done;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [8:0]  ram_addr;
    logic [31:0] ram_do;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;

    logic [31:0] mem [0:511];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [32:0] exp_q [$];
    logic [8:0]  addr_q [$];
    int occ_b = 0;
    int prev_en = 0;
    bit prev_stall = 1'b0;
    logic [32:0] held = 33'd0;
    int en_cnt, hs_cnt, last_cnt, first_en, first_valid, last_hs, done_cyc, start_cyc;

    typedef struct {
        logic [8:0] base;
        logic [9:0] blen;
        int         mode;
        int         exp_en;
        bit         contig;
    } vec_t;

    vec_t vecs [5];

    dffram_burst_reader dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_do    (ram_do),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // DFFRAM read port: data one cycle after EN0, zero when not enabled.
    always @(posedge CLK) begin
        if (ram_en) ram_do <= mem[ram_addr];
        else        ram_do <= 32'd0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic ready_val(input int mode, input int n);
        logic [5:0] pat;
        pat = 6'b101001;
        if (mode == 0) return 1'b1;
        if (n < 6) return pat[n];
        return 1'($urandom_range(0, 1));
    endfunction

    // Per-cycle observation at the negative edge.
    task automatic monitor();
        logic pop_now;
        pop_now = m_valid && m_ready;
        chk("ram_we_zero", 64'(ram_we), 64'd0);
        chk("valid_vs_model", 64'(m_valid), 64'(occ_b > 0));
        if (start && !busy) start_cyc = cyc;
        if (ram_en) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            chk("credit_rule", 64'((occ_b + prev_en - int'(pop_now)) < 2), 64'd1);
            chk("ram_en_expected", 64'(addr_q.size() != 0), 64'd1);
            if (addr_q.size() != 0) chk("ram_addr", 64'(ram_addr), 64'(addr_q.pop_front()));
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (prev_stall) chk("stall_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, held}));
        if (pop_now) begin
            hs_cnt++;
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("m_last_data", 64'({m_last, m_data}), 64'(exp_q.pop_front()));
            if (m_last) begin
                last_cnt++;
                last_hs = cyc;
            end
        end
        if (done) done_cyc = cyc;
        occ_b      = occ_b + prev_en - int'(pop_now);
        prev_en    = int'(ram_en);
        prev_stall = m_valid && !m_ready;
        held       = {m_last, m_data};
    endtask

    task automatic run_burst(input logic [8:0] b, input logic [9:0] l, input int mode,
                             input int inject, input int exp_en, input bit contig);
        int budget;
        int n;
        bit fin;
        logic [8:0] a;
        budget = int'(l) * 12 + 40;
        n = 0;
        fin = 1'b0;
        en_cnt = 0; hs_cnt = 0; last_cnt = 0;
        first_en = -1; first_valid = -1; last_hs = -1; done_cyc = -1; start_cyc = -1;
        for (int k = 0; k < int'(l); k++) begin
            a = b + k[8:0];
            addr_q.push_back(a);
            exp_q.push_back({(k == int'(l) - 1), mem[a]});
        end
        @(posedge CLK); #1;
        base_addr = b; len = l; start = 1'b1; m_ready = ready_val(mode, 0);
        while (!fin && n < budget) begin
            @(negedge CLK);
            monitor();
            if (done) fin = 1'b1;
            @(posedge CLK); #1;
            n++;
            start = (n == inject);
            if (start) begin
                base_addr = ~b;
                len = 10'd3;
            end
            m_ready = ready_val(mode, n);
        end
        start = 1'b0;
        chk("burst_completed", 64'(fin), 64'd1);
        @(negedge CLK);
        monitor();
        chk("done_single_pulse", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
        chk("ram_en_count", 64'(en_cnt), 64'(exp_en));
        chk("word_count", 64'(hs_cnt), 64'(l));
        chk("last_count", 64'(last_cnt), (l != 10'd0) ? 64'd1 : 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);
        if (l != 10'd0) begin
            chk("lat_start_to_en", 64'(first_en - start_cyc), 64'd1);
            chk("lat_en_to_valid", 64'(first_valid - first_en), 64'd2);
            chk("lat_last_to_done", 64'(done_cyc - last_hs), 64'd1);
            if (contig) chk("contiguous_valid", 64'(last_hs - first_valid + 1), 64'(l));
        end else begin
            chk("empty_done_lat", 64'(done_cyc - start_cyc), 64'd1);
            chk("empty_no_valid", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h5A00_0001 + i * 32'h0001_0101;
        vecs[0] = '{9'h010, 10'd4,   0, 4,   1'b1};
        vecs[1] = '{9'h1FE, 10'd4,   0, 4,   1'b1};
        vecs[2] = '{9'h0A0, 10'd8,   2, 8,   1'b0};
        vecs[3] = '{9'h055, 10'd0,   0, 0,   1'b0};
        vecs[4] = '{9'h100, 10'd512, 0, 512, 1'b1};

        RST = 1'b1; start = 1'b0; base_addr = 9'd0; len = 10'd0; m_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_burst(vecs[v].base, vecs[v].blen, vecs[v].mode, -1, vecs[v].exp_en, vecs[v].contig);
        end

        // Start pulse while busy must not disturb a len-5 burst.
        run_burst(9'h1F0, 10'd5, 0, 2, 5, 1'b1);

        // Reset three cycles into a stalled len-16 burst.
        @(posedge CLK); #1;
        base_addr = 9'h020; len = 10'd16; start = 1'b1; m_ready = 1'b0;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("busy_before_rst", 64'(busy), 64'd1);
        chk("word_held_before_rst", 64'(m_valid), 64'd1);
        RST = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ram_en", 64'(ram_en), 64'd0);
        chk("midrst_ram_addr", 64'(ram_addr), 64'd0);
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_m_data", 64'(m_data), 64'd0);
        chk("midrst_m_last", 64'(m_last), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("post_rst_no_valid", 64'(m_valid), 64'd0);
            chk("post_rst_no_en", 64'(ram_en), 64'd0);
        end
        occ_b = 0; prev_en = 0; prev_stall = 1'b0;
        exp_q.delete(); addr_q.delete();
        run_burst(9'h000, 10'd2, 0, -1, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
